// File: rtl/router_rd_drain.sv
// rtl/router_rd_drain.sv - router output-port reader with parity/address check and stream replay
module router_rd_drain #(
    parameter logic [1:0] PORT_ID   = 2'd0,
    parameter int         START_DLY = 2,
    parameter int         TIMEOUT   = 29
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        vld_out,
    input  logic [7:0]  data_out,
    output logic        read_enb,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sop,
    output logic        out_eop,
    output logic        out_err,
    input  logic        out_ready,
    output logic [15:0] pkt_cnt,
    output logic [15:0] err_cnt,
    output logic        timeout_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [4:0]  dly_q, dly_d;
    logic [6:0]  ic_q, ic_d;
    logic [6:0]  wp_q, wp_d;
    logic [6:0]  rp_q, rp_d;
    logic [5:0]  len_q, len_d;
    logic [1:0]  addr_q, addr_d;
    logic [7:0]  xor_q, xor_d;
    logic        err_q, err_d;
    logic        rd_vld_q;
    logic        read_enb_q, read_enb_d;
    logic [15:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic        tout_q, tout_d;
    logic [7:0]  mem_q [0:64];

    logic        capture;
    logic        hdr_byte;
    logic [5:0]  len_c;
    logic [6:0]  total_c;
    logic        last_byte;
    logic        eop_c;
    logic        accept;

    // Router data is valid the cycle after a read strobe; the header length is
    // used combinationally in the cycle it appears so the strobe stays contiguous.
    assign capture   = (state_q == S_READ) && rd_vld_q;
    assign hdr_byte  = capture && (wp_q == 7'd0);
    assign len_c     = hdr_byte ? data_out[7:2] : len_q;
    assign total_c   = {1'b0, len_c} + 7'd2;
    assign last_byte = capture && ((wp_q + 7'd1) == total_c);
    assign eop_c     = (rp_q == (wp_q - 7'd1));
    assign accept    = out_valid && out_ready;

    assign read_enb    = read_enb_q;
    assign out_valid   = (state_q == S_DRAIN);
    assign out_data    = out_valid ? mem_q[rp_q] : 8'd0;
    assign out_sop     = out_valid && (rp_q == 7'd0);
    assign out_eop     = out_valid && eop_c;
    assign out_err     = out_valid && eop_c && err_q;
    assign pkt_cnt     = pkt_cnt_q;
    assign err_cnt     = err_cnt_q;
    assign timeout_err = tout_q;

    // Next-state logic for the read/check/replay sequence and the timeout watchdog.
    always_comb begin
        state_d    = state_q;
        dly_d      = dly_q;
        ic_d       = ic_q + {6'd0, read_enb_q};
        wp_d       = wp_q;
        rp_d       = rp_q;
        len_d      = len_q;
        addr_d     = addr_q;
        xor_d      = xor_q;
        err_d      = err_q;
        read_enb_d = 1'b0;
        pkt_cnt_d  = pkt_cnt_q;
        err_cnt_d  = err_cnt_q;
        tcnt_d     = 8'd0;
        tout_d     = 1'b0;

        if (vld_out && !read_enb_q) begin
            if ((tcnt_q + 8'd1) == 8'(TIMEOUT)) begin
                tout_d = 1'b1;
            end else begin
                tcnt_d = tcnt_q + 8'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                ic_d  = 7'd0;
                wp_d  = 7'd0;
                rp_d  = 7'd0;
                xor_d = 8'd0;
                if (vld_out) begin
                    if (START_DLY == 0) begin
                        state_d    = S_READ;
                        read_enb_d = 1'b1;
                    end else begin
                        dly_d   = 5'(START_DLY);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (dly_q <= 5'd1) begin
                    dly_d      = 5'd0;
                    state_d    = S_READ;
                    read_enb_d = 1'b1;
                end else begin
                    dly_d = dly_q - 5'd1;
                end
            end
            S_READ: begin
                // Before the header arrives the length is unknown; every packet
                // needs at least two reads so the strobe is simply held.
                if (read_enb_q) begin
                    read_enb_d = (!rd_vld_q && (wp_q == 7'd0)) ? 1'b1 : (ic_d < total_c);
                end
                if (capture) begin
                    wp_d  = wp_q + 7'd1;
                    xor_d = xor_q ^ data_out;
                    if (hdr_byte) begin
                        len_d  = data_out[7:2];
                        addr_d = data_out[1:0];
                    end
                    if (last_byte) begin
                        state_d = S_CHECK;
                    end
                end
                // vld_out falling with reads still in flight means the router
                // flushed its FIFO: drop the partial packet and count it.
                if (!vld_out && read_enb_q) begin
                    read_enb_d = 1'b0;
                    state_d    = S_IDLE;
                    wp_d       = 7'd0;
                    rp_d       = 7'd0;
                    if (err_cnt_q != 16'hFFFF) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                end
            end
            S_CHECK: begin
                // The running XOR covers the parity byte too, so a good packet folds to zero.
                err_d   = (xor_q != 8'd0) || (addr_q != PORT_ID);
                rp_d    = 7'd0;
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (accept) begin
                    if (eop_c) begin
                        if (err_q) begin
                            if (err_cnt_q != 16'hFFFF) begin
                                err_cnt_d = err_cnt_q + 16'd1;
                            end
                        end else if (pkt_cnt_q != 16'hFFFF) begin
                            pkt_cnt_d = pkt_cnt_q + 16'd1;
                        end
                        wp_d    = 7'd0;
                        rp_d    = 7'd0;
                        state_d = S_IDLE;
                    end else begin
                        rp_d = rp_q + 7'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= S_IDLE;
            dly_q      <= 5'd0;
            ic_q       <= 7'd0;
            wp_q       <= 7'd0;
            rp_q       <= 7'd0;
            len_q      <= 6'd0;
            addr_q     <= 2'd0;
            xor_q      <= 8'd0;
            err_q      <= 1'b0;
            rd_vld_q   <= 1'b0;
            read_enb_q <= 1'b0;
            pkt_cnt_q  <= 16'd0;
            err_cnt_q  <= 16'd0;
            tcnt_q     <= 8'd0;
            tout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dly_q      <= dly_d;
            ic_q       <= ic_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            xor_q      <= xor_d;
            err_q      <= err_d;
            rd_vld_q   <= read_enb_q;
            read_enb_q <= read_enb_d;
            pkt_cnt_q  <= pkt_cnt_d;
            err_cnt_q  <= err_cnt_d;
            tcnt_q     <= tcnt_d;
            tout_q     <= tout_d;
        end
    end

    // Single-packet buffer written as bytes return from the router.
    always_ff @(posedge clock) begin
        if (capture) begin
            mem_q[wp_q] <= data_out;
        end
    end

endmodule

// File: tb/tb_router_rd_drain.sv
// tb/tb_router_rd_drain.sv - scoreboard bench for router_rd_drain
module tb_router_rd_drain;

    localparam logic [1:0] PORT_ID   = 2'd0;
    localparam int         START_DLY = 2;
    localparam int         TIMEOUT   = 29;

    logic        clock;
    logic        rst;
    logic        vld_out;
    logic [7:0]  data_out;
    logic        read_enb;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_sop;
    logic        out_eop;
    logic        out_err;
    logic        out_ready;
    logic [15:0] pkt_cnt;
    logic [15:0] err_cnt;
    logic        timeout_err;

    router_rd_drain #(.PORT_ID(PORT_ID), .START_DLY(START_DLY), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .rst(rst), .vld_out(vld_out), .data_out(data_out),
        .read_enb(read_enb), .out_data(out_data), .out_valid(out_valid),
        .out_sop(out_sop), .out_eop(out_eop), .out_err(out_err),
        .out_ready(out_ready), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt),
        .timeout_err(timeout_err)
    );

    typedef struct {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       err;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] rq[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         exp_pkt  = 0;
    int         exp_err  = 0;
    int         abort_at = 0;
    int         nread    = 0;
    logic [7:0] nxt      = 8'd0;
    bit         pend     = 0;
    bit         hold_rdy = 0;
    bit         rand_rdy = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Router FIFO model: pops on a sampled read strobe, presents data the next cycle.
    initial forever begin
        @(negedge clock);
        pend = 0;
        if (read_enb && rq.size() != 0) begin
            nxt  = rq.pop_front();
            pend = 1;
            nread++;
            if (abort_at != 0 && nread == abort_at) rq.delete();
        end
    end

    initial forever begin
        @(posedge clock);
        #1;
        if (pend) data_out = nxt;
        vld_out = (rq.size() != 0);
    end

    initial forever begin
        @(negedge clock);
        out_ready = hold_rdy ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    // Monitor: scoreboard pops on accept, stall stability, timeout reference.
    initial begin
        exp_t       e;
        exp_t       h;
        bit         held   = 0;
        int         run    = 0;
        logic       exp_to = 1'b0;
        forever begin
            @(negedge clock);
            #1;
            chk("timeout_err", timeout_err, exp_to);
            if (rst) begin
                run = 0; exp_to = 1'b0;
            end else if (vld_out && !read_enb) begin
                run++;
                if (run == TIMEOUT) begin exp_to = 1'b1; run = 0; end
                else exp_to = 1'b0;
            end else begin
                run = 0; exp_to = 1'b0;
            end

            if (rst) begin
                held = 0;
            end else begin
                if (held) begin
                    chk("stall_valid", out_valid, 1'b1);
                    chk("stall_data", out_data, h.data);
                    chk("stall_sop", out_sop, h.sop);
                    chk("stall_eop", out_eop, h.eop);
                    chk("stall_err", out_err, h.err);
                end
                held = 0;
                if (out_valid) begin
                    if (out_ready) begin
                        if (sbq.size() == 0) begin
                            n_checks++;
                            $display("FAIL unexpected_byte: got data 0x%0h, expected no output", out_data);
                        end else begin
                            e = sbq.pop_front();
                            chk("out_data", out_data, e.data);
                            chk("out_sop", out_sop, e.sop);
                            chk("out_eop", out_eop, e.eop);
                            chk("out_err", out_err, e.err);
                        end
                    end else begin
                        held = 1;
                        h.data = out_data; h.sop = out_sop; h.eop = out_eop; h.err = out_err;
                    end
                end
            end
        end
    end

    task automatic send_pkt(input int len, input logic [1:0] addr, input bit corrupt,
                            input bit fixed, input bit expect_out);
        logic [7:0] b[$];
        logic [7:0] par;
        logic [7:0] p;
        bit         bad;
        par = {len[5:0], addr};
        b.push_back(par);
        for (int i = 0; i < len; i++) begin
            p = fixed ? 8'(8'h11 * (i + 1)) : 8'($urandom);
            b.push_back(p);
            par = par ^ p;
        end
        if (corrupt) par = par ^ 8'(1 << $urandom_range(0, 7));
        b.push_back(par);
        bad = corrupt || (addr != PORT_ID);
        if (expect_out) begin
            for (int i = 0; i < b.size(); i++) begin
                exp_t e;
                e.data = b[i];
                e.sop  = (i == 0);
                e.eop  = (i == b.size() - 1);
                e.err  = (i == b.size() - 1) && bad;
                sbq.push_back(e);
            end
            if (bad) exp_err++;
            else exp_pkt++;
        end
        for (int i = 0; i < b.size(); i++) rq.push_back(b[i]);
    endtask

    task automatic wait_done(input string name);
        int quiet = 0;
        int k     = 0;
        while (quiet < 4 && k < 600) begin
            @(negedge clock);
            k++;
            if (rq.size() == 0 && sbq.size() == 0 && !out_valid && !read_enb) quiet++;
            else quiet = 0;
        end
        if (quiet < 4) begin
            n_checks++;
            $display("FAIL %s_drain: got still busy after 600 cycles, expected idle", name);
        end
        chk({name, "_pkt_cnt"}, pkt_cnt, exp_pkt);
        chk({name, "_err_cnt"}, err_cnt, exp_err);
    endtask

    initial begin
        int first_re;
        int last_re;
        int n_re;
        int first_ov;
        int n_to;
        int to_at;
        bit saw;
        bit done;
        rst = 1'b1; vld_out = 1'b0; data_out = 8'd0; out_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_read_enb", read_enb, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'd0);
        chk("rst_sop_eop_err", {out_sop, out_eop, out_err}, 3'b000);
        chk("rst_pkt_cnt", pkt_cnt, 16'd0);
        chk("rst_err_cnt", err_cnt, 16'd0);
        chk("rst_timeout", timeout_err, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clock);

        // Good packet with latency/strobe-shape checks.
        send_pkt(3, 2'd0, 0, 1, 1);
        first_re = -1; last_re = -1; n_re = 0; first_ov = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (read_enb) begin
                if (first_re < 0) first_re = i;
                last_re = i;
                n_re++;
            end
            if (out_valid && first_ov < 0) first_ov = i;
        end
        chk("t1_re_start", first_re, 3);
        chk("t1_re_count", n_re, 5);
        chk("t1_re_contig", last_re - first_re + 1, 5);
        chk("t1_valid_start", first_ov, 10);
        wait_done("t1");

        // Corrupt parity.
        send_pkt(3, 2'd0, 1, 1, 1);
        wait_done("t2");

        // len=0 with wrong address.
        send_pkt(0, 2'd1, 0, 0, 1);
        n_re = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (read_enb) n_re++;
        end
        chk("t3_reads", n_re, 2);
        wait_done("t3");

        // Random packets with random back-pressure, plus maximum length.
        rand_rdy = 1;
        for (int n = 0; n < 12; n++) begin
            send_pkt($urandom_range(0, 20),
                     ($urandom_range(0, 3) == 0) ? 2'($urandom) : PORT_ID,
                     ($urandom_range(0, 3) == 0), 0, 1);
            wait_done("rand");
        end
        send_pkt(63, PORT_ID, 0, 0, 1);
        wait_done("maxlen");
        rand_rdy = 0;

        // Abort: router flushes after three reads.
        nread = 0; abort_at = 3;
        send_pkt(8, 2'd0, 0, 0, 0);
        exp_err++;
        saw = 0; done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clock);
            if (read_enb) saw = 1;
            if (saw && !vld_out) begin
                @(negedge clock);
                chk("abort_re_drop", read_enb, 1'b0);
                done = 1;
            end
        end
        if (!done) begin
            n_checks++;
            $display("FAIL abort_seen: got no vld_out drop, expected one within 60 cycles");
        end
        abort_at = 0;
        wait_done("abort");

        // Stall in DRAIN while the next packet waits: timeout pulse.
        hold_rdy = 1;
        send_pkt(3, 2'd0, 0, 1, 1);
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clock);
            if (out_valid) done = 1;
        end
        chk("t5_reached_drain", done, 1'b1);
        send_pkt(5, 2'd0, 0, 0, 1);
        n_to = 0; to_at = -1; n_re = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (timeout_err) begin n_to++; to_at = i; end
            if (read_enb) n_re++;
        end
        chk("t5_timeout_pulses", n_to, 1);
        chk("t5_timeout_cycle", to_at, 29);
        chk("t5_no_read_in_drain", n_re, 0);
        hold_rdy = 0;
        wait_done("t5");

        // Reset in the middle of a read.
        send_pkt(10, 2'd0, 0, 0, 0);
        n_re = 0;
        for (int i = 0; i < 40 && n_re < 2; i++) begin
            @(negedge clock);
            if (read_enb) n_re++;
        end
        chk("t6_reading", n_re, 2);
        rst = 1'b1;
        rq.delete();
        @(negedge clock);
        chk("t6_read_enb", read_enb, 1'b0);
        chk("t6_out_valid", out_valid, 1'b0);
        chk("t6_out_data", out_data, 8'd0);
        chk("t6_sop_eop_err", {out_sop, out_eop, out_err}, 3'b000);
        chk("t6_pkt_cnt", pkt_cnt, 16'd0);
        chk("t6_err_cnt", err_cnt, 16'd0);
        @(negedge clock);
        rst = 1'b0;
        exp_pkt = 0; exp_err = 0;
        sbq.delete();
        repeat (2) @(negedge clock);
        send_pkt(2, PORT_ID, 0, 0, 1);
        wait_done("t6_post");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/router_rd_drain.md
# router_rd_drain

Read-side consumer for one router output port. Detects `vld_out`, drives `read_enb` to pull a complete packet (header, payload, parity) into a single-packet buffer, and checks parity and destination address. It then replays the packet on a valid/ready byte stream with sop/eop/err markers. It sits directly downstream of the router output FIFO and services it inside the router's 30-cycle read timeout.

## Interface

Parameters:
- `PORT_ID`, default 2'd0: expected header address bits [1:0].
- `START_DLY`, default 2: idle cycles between `vld_out` sampled high and first `read_enb`; legal range 0..20.
- `TIMEOUT`, default 29: `vld_out`-high-without-read cycle count that raises `timeout_err`.

Ports:
- `clock`, in, 1: single clock, all logic on posedge.
- `rst`, in, 1: synchronous, active-high reset.
- `vld_out`, in, 1: router port has data.
- `data_out`, in, 8: router read data; valid the cycle after `read_enb` is high.
- `read_enb`, out, 1: registered read strobe to the router.
- `out_data`, out, 8: replayed byte.
- `out_valid`, out, 1: byte valid.
- `out_sop` / `out_eop`, out, 1 each: first (header) byte / last (parity) byte.
- `out_err`, out, 1: valid with `out_eop`; parity or address error.
- `out_ready`, in, 1: downstream accept.
- `pkt_cnt`, out, 16: good packets replayed, saturating.
- `err_cnt`, out, 16: errored or aborted packets, saturating.
- `timeout_err`, out, 1: one-cycle pulse.

## Operation

- Packet format: header = {len[5:0], addr[1:0]}, then len payload bytes, then parity = XOR of header and all payload bytes. Total 2..65 bytes.
- Buffer: 65×8 array, write pointer `wp`, read pointer `rp`, each 7 bits.
- FSM states:
  - IDLE: when `vld_out`=1, load the delay counter with START_DLY and go to WAIT. With START_DLY=0, go directly to READ.
  - WAIT: decrement the counter; at 0 go to READ.
  - READ: `read_enb` held high. Each byte returned from `data_out` is written to buf[wp] and `wp` increments. A running XOR is kept.
  - CHECK: one cycle. Compare the parity byte with the running XOR of the preceding bytes, and check addr == PORT_ID. Latch the err flag, then go to DRAIN.
  - DRAIN: present buf[rp]. `rp` advances on `out_valid & out_ready`. After the eop byte is accepted, increment `pkt_cnt` (err=0) or `err_cnt` (err=1), clear `wp`/`rp`, and go to IDLE.
- Read count: the issued-read counter `ic` increments each cycle `read_enb`=1.
  - In the cycle the header is on `data_out` (second READ cycle), the next `read_enb` = (ic < len+2), using `data_out[7:2]` combinationally.
  - Thereafter `read_enb` stays high while ic < len+2.
  - Exactly len+2 reads are issued. READ exits to CHECK the cycle after the final byte is captured.
- Abort: `vld_out` falling while in READ with reads still outstanding means the router soft-reset its FIFO.
  - Drop `read_enb` immediately and increment `err_cnt`.
  - Discard the buffer; nothing is replayed. Go to IDLE.
- Timeout: a separate counter runs while `vld_out`=1 and `read_enb`=0, clearing otherwise. When it reaches TIMEOUT, pulse `timeout_err` and clear the counter. No FSM change.
- No new packet is read while in CHECK or DRAIN; router-side waiting is counted by the timeout counter.
- Counters saturate at 16'hFFFF.

## Timing

- Reset values: `read_enb`=0, `out_valid`=0, `out_sop`=0, `out_eop`=0, `out_err`=0, `out_data`=0, `pkt_cnt`=0, `err_cnt`=0, `timeout_err`=0. FSM=IDLE, pointers 0.
- Reset mid-packet aborts without counting.
- Latency, START_DLY=2:
  - `vld_out` high at cycle 0 → `read_enb` high at cycle 3.
  - Header captured at end of cycle 4.
  - Last byte captured one cycle after last `read_enb`.
  - CHECK one cycle later.
  - `out_valid` high the following cycle.
- `read_enb` is contiguous within a packet: a single high pulse of exactly len+2 cycles.
- Handshake:
  - `out_data`/`out_sop`/`out_eop`/`out_err` are stable while `out_valid` & !`out_ready`.
  - `out_valid` stays high throughout DRAIN.
  - Full throughput: one byte per cycle with `out_ready`=1.
- Same cycle as eop accept: a new `vld_out` is ignored until IDLE (next cycle).
- len=0: two reads; replay is header (sop) then parity (eop).

## Test plan

- Good packet, PORT_ID=0, header 8'h0C (len 3, addr 0), payload 11,22,33, correct parity, `out_ready`=1 → `read_enb` high exactly 5 cycles starting cycle 3; 5 bytes replayed; err=0; `pkt_cnt`=1.
- Corrupt parity byte on the same packet → replay completes with `out_err`=1 on eop; `err_cnt`=1; `pkt_cnt`=0.
- Header 8'h01 (len 0, addr 1) with PORT_ID=0 → 2 reads; `out_sop` on byte 0, `out_eop` on byte 1; `out_err`=1.
- `vld_out` dropped after 3 of 10 reads → `read_enb` low the next cycle; no `out_valid`; `err_cnt`+1; FSM returns to IDLE.
- Hold `out_ready`=0 for 40 cycles during DRAIN while `vld_out`=1 for the next packet → `timeout_err` pulses at cycle 29 of the wait; replayed bytes unchanged; next packet read after eop accept.
- `rst` asserted mid-READ → all outputs at reset values the next cycle; counters 0.
